booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth multiplier for the datapath ALU's MUL operation.
- Takes two 32-bit signed operands from the bus-side operand registers (Y and bus value).
- Produces a 64-bit signed product one bit per clock.
- Feeds the ZHI/ZLO general registers directly: its product outputs drive their D inputs, and done drives their enables.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- clr  input  1  synchronous, active-high reset
- start  input  1  request to begin a multiply; sampled on rising clk
- multiplicand  input  WIDTH  signed operand M, captured when start is accepted
- multiplier  input  WIDTH  signed operand Q, captured when start is accepted
- busy  output  1  high while an operation is iterating
- done  output  1  one-cycle pulse; product valid and stable
- product_hi  output  WIDTH  upper half of the signed product (to ZHI D)
- product_lo  output  WIDTH  lower half of the signed product (to ZLO D)

Behaviour:
- Clock and reset: single clock clk; clr is synchronous, active-high, and has priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, iteration counter=0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge N captures M, clears accumulator A (WIDTH+1 bits, sign-extended), loads Q, clears Q[-1]=0 and count=0, then goes to RUN. busy=1 from edge N.
  - RUN: at each edge, inspect {Q[0],Q[-1]}.
    - 01: A += sext(M)
    - 10: A -= sext(M)
    - 00/11: no add
    - Then arithmetic-shift {A,Q,Q[-1]} right by 1 and increment count.
    - After the WIDTH-th iteration (edge N+WIDTH), go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. product_hi/product_lo are registered from {A[WIDTH-1:0],Q} at edge N+WIDTH.
    - Next edge: start=1 is accepted as a new operation (goes to RUN); otherwise goes to IDLE.
- Latency: done is high in the cycle following edge N+WIDTH, i.e. WIDTH+1 cycles after the start edge. Back-to-back issue is possible every WIDTH+1 cycles.
- product_hi/product_lo hold their value until the next operation completes or clr. They are not updated during RUN; internal working registers are separate from the output registers.
- start while RUN is ignored. Operands are not re-sampled, and the operand inputs may change freely after the accepting edge.
- Width rule: the accumulator is WIDTH+1 bits so that subtracting M = -2^(WIDTH-1) cannot overflow. The result is the exact two's-complement 2*WIDTH-bit product for all operand pairs, including (-2^31)*(-2^31) = 2^62.
- Reset mid-operation: clr during RUN or DONE returns to IDLE on that edge. busy=0, done=0, outputs=0; no done pulse is emitted for the aborted operation.
- Simultaneous clr and start: clr wins; start is dropped.
- start held high continuously: an operation restarts from DONE each time, with no idle gap.

Decomposition:
- Shared package mul_div_pkg holds:
  - state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
  - WIDTH default
  - Booth op codes (NOP/ADD/SUB)
- Package will be reused by the planned sequential divider.
- One combinational sub-module, booth_step: inputs {A,Q,Q[-1]} and M; outputs the next {A,Q,Q[-1]}. It is unit-testable in isolation.
- The FSM, counter and output registers live in booth_mul_seq.

Test Plan:
1. Basic positive: M=7, Q=6, start pulse → done exactly 33 cycles after the start edge. product_hi=0x00000000, product_lo=0x0000002A; busy high for 32 cycles.
2. Mixed sign: M=-3 (0xFFFFFFFD), Q=5 → product_hi=0xFFFFFFFF, product_lo=0xFFFFFFF1 (-15). Then M=0x7FFFFFFF, Q=0x7FFFFFFF → product_hi=0x3FFFFFFF, product_lo=0x00000001.
3. Extreme operand: M=Q=0x80000000 → product_hi=0x40000000, product_lo=0x00000000. Also M=0x80000000, Q=1 → product_hi=0xFFFFFFFF, product_lo=0x80000000.
4. Abort: start with M=9, Q=9; assert clr at cycle 10 → next cycle busy=0, done=0, outputs=0. No done pulse follows. A new start with M=2, Q=3 then yields product_lo=6.
5. Start ignored while busy: start with M=4, Q=4; pulse start with M=100, Q=100 at cycle 5 → single done with product_lo=16 at cycle 33.
6. Back-to-back: hold start high with M=-1, Q=-1 then M=2, Q=-2 presented on the DONE cycle → done pulses at cycles 33 and 66. Products read 1, then -4 (hi=0xFFFFFFFF, lo=0xFFFFFFFC). Outputs hold the first product between the two pulses.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types for the sequential multiply/divide units: FSM states, default width, Booth ops.
// No timing of its own; consumed by booth_mul_seq and the planned divider.
// No flow control here; holds types and a decode helper only.
package mul_div_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_t;

    // Radix-2 Booth recoding of the pair {Q[0], Q[-1]}.
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic shift of {A,Q,Q[-1]}.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to register the result.
module booth_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             qm1_in,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] q_out,
    output logic             qm1_out
);

    booth_op_t        op;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;

    assign op    = booth_decode(q_in[0], qm1_in);
    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = acc_in;
        case (op)
            BOOTH_ADD: sum = acc_in + m_ext;
            BOOTH_SUB: sum = acc_in - m_ext;
            default:   sum = acc_in;
        endcase
    end

    // The extra accumulator bit keeps the sign correct when subtracting the most negative M.
    assign acc_out = {sum[WIDTH], sum[WIDTH:1]};
    assign q_out   = {sum[0], q_in[WIDTH-1:1]};
    assign qm1_out = q_in[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed Booth multiplier feeding ZHI/ZLO; done enables their load.
// Latency WIDTH+1 cycles from the accepting start edge to the done cycle; back-to-back every WIDTH+1.
// No backpressure: start is ignored while iterating and accepted again on the done cycle.
module booth_mul_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;

    logic [WIDTH:0]     acc_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic               qm1_nxt;
    logic               accept;
    logic               last_iter;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_in  (acc_q),
        .q_in    (q_q),
        .qm1_in  (qm1_q),
        .m       (m_q),
        .acc_out (acc_nxt),
        .q_out   (q_nxt),
        .qm1_out (qm1_nxt)
    );

    assign last_iter = (count_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                m_q     <= multiplicand;
                acc_q   <= '0;
                q_q     <= multiplier;
                qm1_q   <= 1'b0;
                count_q <= '0;
            end else if (state_q == ST_RUN) begin
                acc_q   <= acc_nxt;
                q_q     <= q_nxt;
                qm1_q   <= qm1_nxt;
                count_q <= count_q + 1'b1;
                // Output registers only move on the final iteration so ZHI/ZLO see a stable value.
                if (last_iter) begin
                    product_hi <= acc_nxt[WIDTH-1:0];
                    product_lo <= q_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq against a plain signed-multiply reference.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] prod();
        return {product_hi, product_lo};
    endfunction

    task automatic do_mul(input logic [31:0] m, input logic [31:0] q, input string tag);
        int lat;
        int bcnt;
        logic [63:0] exp_p;
        exp_p = ref_mul(m, q);
        @(negedge clk);
        start = 1'b1; multiplicand = m; multiplier = q;
        @(posedge clk);
        #1;
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
        lat = 0;
        bcnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd33);
        chk({tag, " busy cycles"}, 64'(bcnt), 64'd32);
        chk({tag, " busy at done"}, {63'b0, busy}, 64'd0);
        chk({tag, " product"}, prod(), exp_p);
        @(negedge clk);
        chk({tag, " done width"}, {63'b0, done}, 64'd0);
        chk({tag, " hold"}, prod(), exp_p);
    endtask

    initial begin
        int ndone;
        int first_lat;
        int second_lat;
        logic [63:0] got_p;

        clr = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset product", prod(), 64'd0);
        clr = 1'b0;

        do_mul(32'd7, 32'd6, "pos");
        do_mul(32'hFFFF_FFFD, 32'd5, "mixed");
        do_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxpos");
        do_mul(32'h8000_0000, 32'h8000_0000, "minmin");
        do_mul(32'h8000_0000, 32'd1, "min1");
        do_mul(32'd1, 32'h8000_0000, "1min");
        do_mul(32'd0, 32'hFFFF_FFFF, "zero");

        // Abort mid-run: outputs clear and no done follows.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort busy", {63'b0, busy}, 64'd0);
        chk("abort done", {63'b0, done}, 64'd0);
        chk("abort product", prod(), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        do_mul(32'd2, 32'd3, "after abort");

        // clr and start together: start is dropped.
        @(negedge clk);
        clr = 1'b1; start = 1'b1; multiplicand = 32'd5; multiplier = 32'd5;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("clr beats start", {63'b0, busy}, 64'd0);

        // start while running is ignored.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd4; multiplier = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        first_lat = 0;
        got_p = '0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1; multiplicand = 32'd100; multiplier = 32'd100;
            end
            if (i == 6) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = i;
                    got_p = prod();
                end
            end
        end
        chk("ignore latency", 64'(first_lat), 64'd33);
        chk("ignore pulses", 64'(ndone), 64'd1);
        chk("ignore product", got_p, 64'd16);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'hFFFF_FFFF; multiplier = 32'hFFFF_FFFF;
        @(posedge clk);
        first_lat = 0;
        second_lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 50) chk("b2b hold", prod(), 64'd1);
            if (done) begin
                if (first_lat == 0) begin
                    first_lat = i;
                    chk("b2b first product", prod(), 64'd1);
                    multiplicand = 32'd2; multiplier = 32'hFFFF_FFFE;
                end else begin
                    second_lat = i;
                    chk("b2b second product", prod(), ref_mul(32'd2, 32'hFFFF_FFFE));
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b first latency", 64'(first_lat), 64'd33);
        chk("b2b second latency", 64'(second_lat), 64'd66);
        @(negedge clk);
        @(negedge clk);
        chk("b2b idle after", {62'b0, busy, done}, 64'd0);

        for (int k = 0; k < 16; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (k % 4 == 1) a = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 31'd0};
            if (k % 4 == 2) b = 32'hFFFF_FFFF;
            do_mul(a, b, $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
